// File: rtl/wave_config_ctrl.sv
// Waveform configuration controller: shadow/live settings for 8 channels with drained commit.
// Optional macro WAVE_CFG_ERR_EN enables the sticky reserved-field error flag.
module wave_config_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [2:0]   wr_chan,
    input  logic [1:0]   wr_field,
    input  logic [15:0]  wr_data,
    input  logic         commit,
    input  logic         run,
    output logic [127:0] amps,
    output logic [127:0] offsets,
    output logic [127:0] phasewords,
    output logic         active_out,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_APPLY
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       drain_cnt_q, drain_cnt_d;
    logic             wr_ready_q, wr_ready_d;
    logic             active_q, active_d;
    logic             busy_q, busy_d;

    logic [7:0][15:0] shadow_amp_q, shadow_amp_d;
    logic [7:0][15:0] shadow_off_q, shadow_off_d;
    logic [7:0][15:0] shadow_phase_q, shadow_phase_d;
    logic [7:0][15:0] live_amp_q, live_amp_d;
    logic [7:0][15:0] live_off_q, live_off_d;
    logic [7:0][15:0] live_phase_q, live_phase_d;

    logic             wr_fire;

    assign wr_fire = wr_valid && wr_ready_q;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (commit) begin
                    state_d = S_APPLY;
                end else if (run) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (commit) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 4'(DRAIN_CYCLES);
                end else if (!run) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                // commit and run are deliberately ignored until the drain finishes
                drain_cnt_d = (drain_cnt_q == 4'd0) ? 4'd0 : drain_cnt_q - 4'd1;
                if (drain_cnt_q <= 4'd1) begin
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                state_d = run ? S_RUN : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        wr_ready_d = (state_d == S_IDLE) || (state_d == S_RUN);
        active_d   = (state_d == S_RUN);
        busy_d     = (state_d == S_DRAIN) || (state_d == S_APPLY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= 4'd0;
            wr_ready_q  <= 1'b0;
            active_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            wr_ready_q  <= wr_ready_d;
            active_q    <= active_d;
            busy_q      <= busy_d;
        end
    end

    // Field 3 is reserved: the write handshake completes but no word is touched.
    always_comb begin
        shadow_amp_d   = shadow_amp_q;
        shadow_off_d   = shadow_off_q;
        shadow_phase_d = shadow_phase_q;
        if (wr_fire) begin
            case (wr_field)
                2'd0:    shadow_amp_d[wr_chan]   = wr_data;
                2'd1:    shadow_off_d[wr_chan]   = wr_data;
                2'd2:    shadow_phase_d[wr_chan] = wr_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        live_amp_d   = live_amp_q;
        live_off_d   = live_off_q;
        live_phase_d = live_phase_q;
        if (state_q == S_APPLY) begin
            live_amp_d   = shadow_amp_q;
            live_off_d   = shadow_off_q;
            live_phase_d = shadow_phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_amp_q   <= '0;
            shadow_off_q   <= '0;
            shadow_phase_q <= '0;
            live_amp_q     <= '0;
            live_off_q     <= '0;
            live_phase_q   <= '0;
        end else begin
            shadow_amp_q   <= shadow_amp_d;
            shadow_off_q   <= shadow_off_d;
            shadow_phase_q <= shadow_phase_d;
            live_amp_q     <= live_amp_d;
            live_off_q     <= live_off_d;
            live_phase_q   <= live_phase_d;
        end
    end

`ifdef WAVE_CFG_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q || (wr_fire && (wr_field == 2'd3));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign wr_ready   = wr_ready_q;
    assign active_out = active_q;
    assign busy       = busy_q;
    assign amps       = live_amp_q;
    assign offsets    = live_off_q;
    assign phasewords = live_phase_q;

endmodule

// File: tb/tb_wave_config_ctrl.sv
// Self-checking bench for wave_config_ctrl: directed vector table, corner sequences,
// then randomized traffic against a window-based reference model.
module tb_wave_config_ctrl;

    localparam int DC = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_valid;
    logic         wr_ready;
    logic [2:0]   wr_chan;
    logic [1:0]   wr_field;
    logic [15:0]  wr_data;
    logic         commit;
    logic         run;
    logic [127:0] amps;
    logic [127:0] offsets;
    logic [127:0] phasewords;
    logic         active_out;
    logic         busy;
    logic         err;

    always #5 clk = ~clk;

    wave_config_ctrl #(.DRAIN_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_chan    (wr_chan),
        .wr_field   (wr_field),
        .wr_data    (wr_data),
        .commit     (commit),
        .run        (run),
        .amps       (amps),
        .offsets    (offsets),
        .phasewords (phasewords),
        .active_out (active_out),
        .busy       (busy),
        .err        (err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a commit opens a blocked window of DC+1 cycles (from RUN)
    // or 1 cycle (from IDLE); the copy to live happens as the window closes.
    logic [15:0] m_shadow [3][8];
    logic [15:0] m_live   [3][8];
    int          m_low_left;
    bit          m_active;
    bit          m_ready_ok;
    bit          m_err;

    typedef struct {
        bit          rst;
        bit          wv;
        logic [2:0]  ch;
        logic [1:0]  fld;
        logic [15:0] dat;
        bit          cm;
        bit          rn;
        bit          e_act;
        bit          e_busy;
        bit          e_rdy;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(bit rst, bit wv, int ch, int fld, int dat, bit cm, bit rn,
                                bit ea, bit eb, bit er);
        vec_t v;
        v.rst = rst; v.wv = wv; v.ch = 3'(ch); v.fld = 2'(fld); v.dat = 16'(dat);
        v.cm = cm; v.rn = rn; v.e_act = ea; v.e_busy = eb; v.e_rdy = er;
        return v;
    endfunction

    function automatic logic [127:0] pack_live(int f);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 8; c++) r[16*c +: 16] = m_live[f][c];
        return r;
    endfunction

    task automatic model_reset();
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 8; c++) begin
                m_shadow[f][c] = 16'h0;
                m_live[f][c]   = 16'h0;
            end
        end
        m_low_left = 0;
        m_active   = 1'b0;
        m_ready_ok = 1'b0;
        m_err      = 1'b0;
    endtask

    task automatic model_edge();
        bit accepted;
        if (reset) begin
            model_reset();
        end else begin
            accepted = wr_valid && m_ready_ok && (m_low_left == 0);
            if (accepted) begin
                if (wr_field == 2'd3) begin
`ifdef WAVE_CFG_ERR_EN
                    m_err = 1'b1;
`endif
                end else begin
                    m_shadow[int'(wr_field)][int'(wr_chan)] = wr_data;
                end
            end
            if (m_low_left > 0) begin
                if (m_low_left == 1) begin
                    m_live   = m_shadow;
                    m_active = run;
                end
                m_low_left--;
            end else if (commit) begin
                m_low_left = m_active ? DC + 1 : 1;
                m_active   = 1'b0;
            end else begin
                m_active = run;
            end
            m_ready_ok = 1'b1;
        end
    endtask

    task automatic checkOutput(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        checkOutput("active_out", 128'(active_out), 128'(m_active));
        checkOutput("busy", 128'(busy), 128'(m_low_left > 0));
        checkOutput("wr_ready", 128'(wr_ready), 128'(m_ready_ok && (m_low_left == 0)));
        checkOutput("err", 128'(err), 128'(m_err));
        checkOutput("amps", amps, pack_live(0));
        checkOutput("offsets", offsets, pack_live(1));
        checkOutput("phasewords", phasewords, pack_live(2));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic applyStimulus(vec_t v);
        reset    = v.rst;
        wr_valid = v.wv;
        wr_chan  = v.ch;
        wr_field = v.fld;
        wr_data  = v.dat;
        commit   = v.cm;
        run      = v.rn;
    endtask

    task automatic idle_inputs(bit rn);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, rn, 0, 0, 0));
    endtask

    initial begin
        model_reset();

        //            rst wv ch fld dat     cm rn  act busy rdy
        tbl[0]  = mk(1,  0, 0, 0, 0,      0, 0,  0,  0,  0);
        tbl[1]  = mk(1,  0, 0, 0, 0,      0, 0,  0,  0,  0);
        tbl[2]  = mk(0,  0, 0, 0, 0,      0, 0,  0,  0,  1);
        tbl[3]  = mk(0,  1, 3, 0, 'h1234, 1, 0,  0,  1,  0);
        tbl[4]  = mk(0,  0, 0, 0, 0,      0, 0,  0,  0,  1);
        tbl[5]  = mk(0,  0, 0, 0, 0,      0, 1,  1,  0,  1);
        tbl[6]  = mk(0,  1, 0, 2, 'h0400, 1, 1,  0,  1,  0);
        tbl[7]  = mk(0,  0, 0, 0, 0,      0, 1,  0,  1,  0);
        tbl[8]  = mk(0,  0, 0, 0, 0,      1, 1,  0,  1,  0);
        tbl[9]  = mk(0,  0, 0, 0, 0,      0, 0,  0,  1,  0);
        tbl[10] = mk(0,  0, 0, 0, 0,      0, 1,  0,  1,  0);
        tbl[11] = mk(0,  0, 0, 0, 0,      0, 1,  0,  1,  0);
        tbl[12] = mk(0,  0, 0, 0, 0,      0, 1,  0,  1,  0);
        tbl[13] = mk(0,  0, 0, 0, 0,      0, 1,  1,  0,  1);
        tbl[14] = mk(0,  1, 7, 1, 'hFFFF, 1, 1,  0,  1,  0);
        tbl[15] = mk(0,  0, 0, 0, 0,      0, 1,  0,  1,  0);
        tbl[16] = mk(1,  0, 0, 0, 0,      0, 1,  0,  0,  0);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(tbl[i]);
            step();
            checkOutput($sformatf("tbl%0d_active", i), 128'(active_out), 128'(tbl[i].e_act));
            checkOutput($sformatf("tbl%0d_busy", i), 128'(busy), 128'(tbl[i].e_busy));
            checkOutput($sformatf("tbl%0d_ready", i), 128'(wr_ready), 128'(tbl[i].e_rdy));
            if (i == 4) checkOutput("idle_commit_amps", amps, 128'h1234 << 48);
            if (i == 13) begin
                checkOutput("run_commit_phase0", 128'(phasewords[15:0]), 128'h0400);
                checkOutput("run_commit_amps", amps, 128'h1234 << 48);
            end
            if (i == 16) begin
                checkOutput("reset_drain_amps", amps, 128'h0);
                checkOutput("reset_drain_offsets", offsets, 128'h0);
                checkOutput("reset_drain_phase", phasewords, 128'h0);
            end
        end

        // Write plus commit in the same IDLE cycle
        idle_inputs(0);
        step();
        applyStimulus(mk(0, 1, 7, 1, 'hFFFF, 1, 0, 0, 0, 0));
        step();
        idle_inputs(0);
        step();
        checkOutput("same_cycle_offsets_ch7", 128'(offsets[127:112]), 128'hFFFF);

        // Reserved-field write, then a commit that must not disturb live outputs
        applyStimulus(mk(0, 1, 2, 3, 'hAAAA, 0, 0, 0, 0, 0));
        step();
        idle_inputs(0);
        step();
`ifdef WAVE_CFG_ERR_EN
        checkOutput("err_set", 128'(err), 128'h1);
`else
        checkOutput("err_tied", 128'(err), 128'h0);
`endif
        applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        step();
        idle_inputs(0);
        step();
        checkOutput("field3_offsets", offsets, 128'hFFFF << 112);
        checkOutput("field3_amps", amps, 128'h0);
        checkOutput("field3_phase", phasewords, 128'h0);
`ifdef WAVE_CFG_ERR_EN
        checkOutput("err_sticky", 128'(err), 128'h1);
`else
        checkOutput("err_still_zero", 128'(err), 128'h0);
`endif

        // Randomized traffic; stalled writes keep their fields stable
        for (int n = 0; n < 3000; n++) begin
            reset  = ($urandom_range(149) == 0);
            commit = ($urandom_range(7) == 0);
            if ($urandom_range(9) == 0) run = ~run;
            if (!(wr_valid && !(m_ready_ok && (m_low_left == 0)))) begin
                wr_valid = ($urandom_range(1) == 1);
                wr_chan  = 3'($urandom_range(7));
                wr_field = ($urandom_range(15) == 0) ? 2'd3 : 2'($urandom_range(2));
                wr_data  = 16'($urandom);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
